// File: rtl/press_sequence_capture.sv
// Debounced 8-button press recorder: captures up to 16 button indices per round.
// Optional idle timeout ends a round early when built with INPUT_TIMEOUT_EN.
module press_sequence_capture #(
   parameter int unsigned DEBOUNCE_CYCLES = 4,
   parameter int unsigned TIMEOUT_CYCLES  = 1000000
) (
   input  logic        clk_1,
   input  logic        rst,
   input  logic        enable,
   input  logic [2:0]  level,
   input  logic [7:0]  btn,
   output logic [47:0] seq,
   output logic [4:0]  count,
   output logic        done,
   output logic        multi_err,
   output logic        timeout
);

   localparam int unsigned N_BTN  = 8;
   localparam int unsigned IDX_W  = 3;
   localparam int unsigned N_SLOT = 16;
   localparam int unsigned CNT_W  = 5;
   localparam int unsigned DB_W   = 4;
   localparam int unsigned SEQ_W  = N_SLOT * IDX_W;

   // Elaboration-time parameter range checks
   if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 15) begin : g_bad_debounce
      $error("DEBOUNCE_CYCLES must be 1..15");
   end
   if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES must be at least 1");
   end

   typedef enum logic [1:0] {IDLE, ARM, CAPTURE, DONE} state_t;

   logic [N_BTN-1:0] sync1, sync2, deb, deb_d;
   logic [DB_W-1:0]  db_cnt [N_BTN];

   state_t           state, state_nxt;
   logic [CNT_W-1:0] target, target_nxt;
   logic [SEQ_W-1:0] seq_nxt;
   logic [CNT_W-1:0] count_nxt;
   logic             done_nxt, multi_err_nxt;

   logic [N_BTN-1:0] press_c;
   logic             multi_c, single_c, onehot_c;
   logic [IDX_W-1:0] idx_c;
   logic [CNT_W-1:0] target_c;

   // Two-flop synchronizer followed by per-button stable-sample debounce
   always_ff @(posedge clk_1 or negedge rst) begin
      if (!rst) begin
         sync1 <= '0;
         sync2 <= '0;
         deb   <= '0;
         deb_d <= '0;
         for (int i = 0; i < N_BTN; i++) db_cnt[i] <= '0;
      end else begin
         sync1 <= btn;
         sync2 <= sync1;
         deb_d <= deb;
         for (int i = 0; i < N_BTN; i++) begin
            if (sync2[i] != deb[i]) begin
               if (db_cnt[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                  deb[i]    <= ~deb[i];
                  db_cnt[i] <= '0;
               end else begin
                  db_cnt[i] <= db_cnt[i] + DB_W'(1);
               end
            end else begin
               db_cnt[i] <= '0;
            end
         end
      end
   end

   // Press events are debounced rising edges only
   always_comb begin
      press_c  = deb & ~deb_d;
      multi_c  = |(press_c & (press_c - N_BTN'(1)));
      single_c = (|press_c) & ~multi_c;
      idx_c    = '0;
      for (int i = 0; i < N_BTN; i++) begin
         if (press_c[i]) idx_c = IDX_W'(i);
      end
      onehot_c = (level == 3'b001) || (level == 3'b010) || (level == 3'b100);
      case (level)
         3'b010:  target_c = CNT_W'(12);
         3'b100:  target_c = CNT_W'(16);
         default: target_c = CNT_W'(8);
      endcase
   end

`ifdef INPUT_TIMEOUT_EN
   localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [TMO_W-1:0] idle_cnt, idle_cnt_nxt;
   logic             timeout_nxt;
`endif

   // Next-state and datapath update
   always_comb begin
      state_nxt     = state;
      target_nxt    = target;
      seq_nxt       = seq;
      count_nxt     = count;
      done_nxt      = 1'b0;
      multi_err_nxt = 1'b0;
`ifdef INPUT_TIMEOUT_EN
      idle_cnt_nxt  = idle_cnt;
      timeout_nxt   = 1'b0;
`endif
      case (state)
         IDLE: begin
            if (enable && onehot_c) begin
               state_nxt  = ARM;
               target_nxt = target_c;
               seq_nxt    = '0;
               count_nxt  = '0;
            end
         end
         ARM: begin
            if (!enable) begin
               state_nxt = IDLE;
            end else if (deb == '0) begin
               state_nxt = CAPTURE;
`ifdef INPUT_TIMEOUT_EN
               idle_cnt_nxt = '0;
`endif
            end
         end
         CAPTURE: begin
            if (!enable) begin
               state_nxt = IDLE;
            end else begin
               if (multi_c) multi_err_nxt = 1'b1;
               if (single_c) begin
                  for (int k = 0; k < N_SLOT; k++) begin
                     if (count[3:0] == 4'(k)) seq_nxt[IDX_W*k +: IDX_W] = idx_c;
                  end
                  count_nxt = count + CNT_W'(1);
`ifdef INPUT_TIMEOUT_EN
                  idle_cnt_nxt = '0;
`endif
                  if (count_nxt == target) begin
                     state_nxt = DONE;
                     done_nxt  = 1'b1;
                  end
               end
`ifdef INPUT_TIMEOUT_EN
               else if (idle_cnt == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                  state_nxt   = DONE;
                  done_nxt    = 1'b1;
                  timeout_nxt = 1'b1;
               end else begin
                  idle_cnt_nxt = idle_cnt + TMO_W'(1);
               end
`endif
            end
         end
         DONE: begin
            if (!enable) begin
               state_nxt = IDLE;
            end else begin
               done_nxt = 1'b1;
`ifdef INPUT_TIMEOUT_EN
               timeout_nxt = timeout;
`endif
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk_1 or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         target    <= '0;
         seq       <= '0;
         count     <= '0;
         done      <= 1'b0;
         multi_err <= 1'b0;
      end else begin
         state     <= state_nxt;
         target    <= target_nxt;
         seq       <= seq_nxt;
         count     <= count_nxt;
         done      <= done_nxt;
         multi_err <= multi_err_nxt;
      end
   end

`ifdef INPUT_TIMEOUT_EN
   always_ff @(posedge clk_1 or negedge rst) begin
      if (!rst) begin
         idle_cnt <= '0;
         timeout  <= 1'b0;
      end else begin
         idle_cnt <= idle_cnt_nxt;
         timeout  <= timeout_nxt;
      end
   end
`else
   assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_press_sequence_capture.sv
// Directed self-checking bench for press_sequence_capture (DEBOUNCE_CYCLES=4, TIMEOUT_CYCLES=50).
module tb_press_sequence_capture;

   localparam int unsigned DEB = 4;
   localparam int unsigned TMO = 50;

   logic        clk_1 = 1'b0;
   logic        rst;
   logic        enable;
   logic [2:0]  level;
   logic [7:0]  btn;
   logic [47:0] seq;
   logic [4:0]  count;
   logic        done;
   logic        multi_err;
   logic        timeout;

   int n_checks = 0;
   int n_errors = 0;
   int n_multi  = 0;

   press_sequence_capture #(
      .DEBOUNCE_CYCLES (DEB),
      .TIMEOUT_CYCLES  (TMO)
   ) dut (
      .clk_1     (clk_1),
      .rst       (rst),
      .enable    (enable),
      .level     (level),
      .btn       (btn),
      .seq       (seq),
      .count     (count),
      .done      (done),
      .multi_err (multi_err),
      .timeout   (timeout)
   );

   always #5 clk_1 = ~clk_1;

   always @(negedge clk_1) begin
      if (multi_err) n_multi++;
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk_1);
   endtask

   task automatic press(input int idx);
      btn[idx] = 1'b1;
      tick(10);
      btn[idx] = 1'b0;
      tick(10);
   endtask

   task automatic start_round(input logic [2:0] lvl);
      enable = 1'b0;
      tick(2);
      level  = lvl;
      enable = 1'b1;
      tick(3);
   endtask

   int p_basic [8] = '{3, 0, 7, 7, 1, 2, 5, 6};
   int multi0;
   int waited;
   int cyc;

   initial begin
      rst    = 1'b0;
      enable = 1'b0;
      level  = 3'b001;
      btn    = '0;
      tick(3);
      check("rst_seq",   64'(seq), 64'h0);
      check("rst_count", 64'(count), 64'h0);
      check("rst_done",  64'(done), 64'h0);
      check("rst_multi", 64'(multi_err), 64'h0);
      check("rst_tmo",   64'(timeout), 64'h0);
      rst = 1'b1;
      tick(2);

      // Eight clean presses at level 001
      start_round(3'b001);
      for (int i = 0; i < 8; i++) press(p_basic[i]);
      check("basic_seq",   64'(seq), 64'hD51FC3);
      check("basic_count", 64'(count), 64'd8);
      check("basic_done",  64'(done), 64'h1);
      check("basic_tmo",   64'(timeout), 64'h0);
      press(4);
      check("done_frozen_seq",   64'(seq), 64'hD51FC3);
      check("done_frozen_count", 64'(count), 64'd8);
      enable = 1'b0;
      tick(1);
      check("disable_done",  64'(done), 64'h0);
      check("disable_count", 64'(count), 64'd8);
      check("disable_seq",   64'(seq), 64'hD51FC3);

      // Bouncing button produces a single event
      start_round(3'b001);
      for (int i = 0; i < 10; i++) begin
         btn[4] = (i % 2 == 0);
         tick(1);
      end
      btn[4] = 1'b1;
      tick(6);
      btn[4] = 1'b0;
      tick(12);
      check("bounce_count", 64'(count), 64'd1);
      check("bounce_seq",   64'(seq), 64'd4);

      // Simultaneous presses are rejected
      start_round(3'b001);
      multi0 = n_multi;
      btn[2] = 1'b1;
      btn[5] = 1'b1;
      tick(10);
      btn = '0;
      tick(10);
      check("multi_pulses", 64'(n_multi - multi0), 64'd1);
      check("multi_count",  64'(count), 64'd0);
      press(6);
      check("after_multi_seq",   64'(seq), 64'd6);
      check("after_multi_count", 64'(count), 64'd1);

      // Button held across enable rise is not captured
      enable = 1'b0;
      btn[1] = 1'b1;
      tick(10);
      level  = 3'b001;
      enable = 1'b1;
      tick(10);
      check("held_count", 64'(count), 64'd0);
      check("held_seq",   64'(seq), 64'd0);
      btn[1] = 1'b0;
      tick(10);
      check("release_count", 64'(count), 64'd0);
      press(1);
      check("held_next_seq",   64'(seq), 64'd1);
      check("held_next_count", 64'(count), 64'd1);

      // Mid-round reset, then a full 16-press round
      start_round(3'b100);
      for (int i = 0; i < 5; i++) press(i);
      check("pre_rst_count", 64'(count), 64'd5);
      #2;
      rst    = 1'b0;
      enable = 1'b0;
      #1;
      check("mid_rst_count", 64'(count), 64'd0);
      check("mid_rst_seq",   64'(seq), 64'd0);
      check("mid_rst_done",  64'(done), 64'd0);
      tick(2);
      rst = 1'b1;
      tick(2);
      check("post_rst_count", 64'(count), 64'd0);
      start_round(3'b100);
      level = 3'b001;
      for (int i = 0; i < 8; i++) press(i);
      check("level_ignored_done",  64'(done), 64'd0);
      check("level_ignored_count", 64'(count), 64'd8);
      for (int i = 0; i < 8; i++) press(i);
      check("full_count", 64'(count), 64'd16);
      check("full_done",  64'(done), 64'd1);
      check("full_seq",   64'(seq), 64'hFAC688FAC688);

`ifdef INPUT_TIMEOUT_EN
      // Idle timeout after the third press
      start_round(3'b010);
      press(1);
      press(2);
      btn[3] = 1'b1;
      waited = 0;
      while (count != 5'd3 && waited < 40) begin
         tick(1);
         waited++;
      end
      check("tmo_accept", 64'(count), 64'd3);
      btn[3] = 1'b0;
      cyc = 0;
      while (!done && cyc < 200) begin
         tick(1);
         cyc++;
      end
      check("tmo_cycles", 64'(cyc), 64'd50);
      check("tmo_flag",   64'(timeout), 64'd1);
      check("tmo_count",  64'(count), 64'd3);
      check("tmo_seq",    64'(seq), 64'h0D1);
      enable = 1'b0;
      tick(1);
      check("tmo_clear", 64'(timeout), 64'd0);
`else
      // Without the timeout build an idle round never ends on its own
      start_round(3'b010);
      press(1);
      tick(120);
      check("no_tmo_done",  64'(done), 64'd0);
      check("no_tmo_flag",  64'(timeout), 64'd0);
      check("no_tmo_count", 64'(count), 64'd1);
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1);
   end

endmodule
